// File: rtl/register_dump_controller_if.sv
// Purpose: handshake/bus bundle between the dump controller, the register file debug port and the UART TX byte port.
// Latency: wires only, no storage.
// Backpressure: none here; the UART paces the controller through tx_start/tx_done.
// Ports (master = controller side):
//   dump_start, dump_abort : control requests into the controller
//   reg_read_addr / reg_read_data : register file debug read port
//   tx_start, tx_data / tx_done : UART byte handoff and completion pulse
//   busy, dump_done : status back to the debug unit
interface register_dump_controller_if #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32
);
   logic                  dump_start;
   logic                  dump_abort;
   logic [ADDR_WIDTH-1:0] reg_read_addr;
   logic [DATA_WIDTH-1:0] reg_read_data;
   logic                  tx_start;
   logic [7:0]            tx_data;
   logic                  tx_done;
   logic                  busy;
   logic                  dump_done;

   modport master (
      input  dump_start, dump_abort, reg_read_data, tx_done,
      output reg_read_addr, tx_start, tx_data, busy, dump_done
   );

   modport slave (
      output dump_start, dump_abort, reg_read_data, tx_done,
      input  reg_read_addr, tx_start, tx_data, busy, dump_done
   );
endinterface

// File: rtl/register_dump_controller.sv
// Purpose: streams a header byte then every register (MSB byte first) to the UART.
// Latency: busy rises one cycle after dump_start; each register costs 1 + READ_LATENCY cycles plus the UART time of its bytes.
// Backpressure: one byte outstanding at a time; the next tx_start waits for tx_done from the UART.
// Ports: clock, reset_n (async, active-low); bus = register_dump_controller_if.master
//   (dump_start/dump_abort in, reg_read_addr out / reg_read_data in, tx_start/tx_data out / tx_done in, busy/dump_done out).
module register_dump_controller #(
   parameter int         NUM_REGS     = 32,
   parameter int         DATA_WIDTH   = 32,
   parameter int         ADDR_WIDTH   = 5,
   parameter int         READ_LATENCY = 1,
   parameter logic [7:0] HEADER_BYTE  = 8'hA5
) (
   input logic                       clock,
   input logic                       reset_n,
   register_dump_controller_if.master bus
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int BCW   = $clog2(BYTES + 1);
   localparam int WCW   = $clog2(READ_LATENCY + 1);

   localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(NUM_REGS - 1);
   localparam logic [BCW-1:0]        BYTES_C   = BCW'(BYTES);
   localparam logic [WCW-1:0]        WAIT_LAST = WCW'(READ_LATENCY - 1);

   typedef enum logic [2:0] {
      IDLE,
      HDR_SEND,
      HDR_WAIT,
      RD_ISSUE,
      RD_WAIT,
      BYTE_SEND,
      BYTE_WAIT,
      DONE
   } state_t;

   state_t                state_q;
   logic [ADDR_WIDTH-1:0] idx_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [WCW-1:0]        wait_q;
   logic [BCW-1:0]        byte_q;
   logic [DATA_WIDTH-1:0] shift_q;
   logic                  tx_start_q;
   logic [7:0]            tx_data_q;
   logic                  busy_q;
   logic                  done_q;

   logic [DATA_WIDTH-1:0] shift_nxt;
   logic [BCW-1:0]        byte_nxt;

   assign shift_nxt = shift_q << 8;
   assign byte_nxt  = byte_q + BCW'(1);

   assign bus.reg_read_addr = addr_q;
   assign bus.tx_start      = tx_start_q;
   assign bus.tx_data       = tx_data_q;
   assign bus.busy          = busy_q;
   assign bus.dump_done     = done_q;

   // Outputs are registered alongside the state: tx_start/tx_data are loaded
   // on the edge that enters a *_SEND state so the pulse lines up with it.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         addr_q     <= '0;
         wait_q     <= '0;
         byte_q     <= '0;
         shift_q    <= '0;
         tx_start_q <= 1'b0;
         tx_data_q  <= 8'h00;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         tx_start_q <= 1'b0;
         done_q     <= 1'b0;
         if (bus.dump_abort && state_q != IDLE) begin
            // Any byte already handed over completes in the UART; its
            // tx_done then lands in IDLE and is ignored.
            state_q <= IDLE;
            busy_q  <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (bus.dump_start && !bus.dump_abort) begin
                     state_q    <= HDR_SEND;
                     busy_q     <= 1'b1;
                     tx_start_q <= 1'b1;
                     tx_data_q  <= HEADER_BYTE;
                  end
               end
               HDR_SEND: state_q <= HDR_WAIT;
               HDR_WAIT: begin
                  if (bus.tx_done) begin
                     idx_q   <= '0;
                     state_q <= RD_ISSUE;
                  end
               end
               RD_ISSUE: begin
                  addr_q  <= idx_q;
                  wait_q  <= '0;
                  state_q <= RD_WAIT;
               end
               RD_WAIT: begin
                  if (wait_q == WAIT_LAST) begin
                     shift_q    <= bus.reg_read_data;
                     byte_q     <= '0;
                     state_q    <= BYTE_SEND;
                     tx_start_q <= 1'b1;
                     tx_data_q  <= bus.reg_read_data[DATA_WIDTH-1 -: 8];
                  end else begin
                     wait_q <= wait_q + WCW'(1);
                  end
               end
               BYTE_SEND: state_q <= BYTE_WAIT;
               BYTE_WAIT: begin
                  if (bus.tx_done) begin
                     shift_q <= shift_nxt;
                     byte_q  <= byte_nxt;
                     if (byte_nxt < BYTES_C) begin
                        state_q    <= BYTE_SEND;
                        tx_start_q <= 1'b1;
                        tx_data_q  <= shift_nxt[DATA_WIDTH-1 -: 8];
                     end else if (idx_q < LAST_IDX) begin
                        // Terminal check precedes the increment, so the index never wraps.
                        idx_q   <= idx_q + ADDR_WIDTH'(1);
                        state_q <= RD_ISSUE;
                     end else begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                     end
                  end
               end
               DONE: begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
               default: begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
